// File: rtl/aes_pkg.sv
// aes_pkg: widths, key-expansion FSM encoding and GF(2^8) helpers shared by the AES blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_pkg;

  localparam int AES_WORD_W  = 32;
  localparam int AES_BLOCK_W = 128;

  // Key-expansion FSM; plain vector encoding so older tools and netlists line up.
  typedef logic [1:0] kx_state_t;
  localparam kx_state_t ST_IDLE   = 2'b00;
  localparam kx_state_t ST_EXPAND = 2'b01;
  localparam kx_state_t ST_DONE   = 2'b10;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] GF_REDUCE = 8'h1b;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1; also used by mixColumns.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? GF_REDUCE : 8'h00);
  endfunction

endpackage

// File: rtl/key_expand_iter_if.sv
// key_expand_iter_if: request/result bundle between a key-schedule consumer and key_expand_iter.
// Latency: n/a (wires only).
// Backpressure: none; consumer raises start, then waits for done.
// Signals: start, Key[0:32*nk-1] (word 0 at bits 0..31), busy, done,
//          keySchedule[0:128*(nr+1)-1] (w[i] at bits [32*i +: 32]).
// Modports: master = consumer side (drives start/Key), slave = expander side.
interface key_expand_iter_if #(
  parameter int nk = 4,
  parameter int nr = 10
);
  import aes_pkg::*;

  logic                           start;
  logic [0:AES_WORD_W*nk-1]       Key;
  logic                           busy;
  logic                           done;
  logic [0:AES_BLOCK_W*(nr+1)-1]  keySchedule;

  modport master (output start, Key, input busy, done, keySchedule);
  modport slave  (input start, Key, output busy, done, keySchedule);
endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box (multiplicative inverse in GF(2^8) + affine map).
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: din[7:0] byte in, dout[7:0] substituted byte out.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  import aes_pkg::*;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse as din^254 via an addition chain; din=0 maps to 0 as AES requires.
  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  assign x2   = gf_mul(din, din);
  assign x3   = gf_mul(x2, din);
  assign x6   = gf_mul(x3, x3);
  assign x12  = gf_mul(x6, x6);
  assign x15  = gf_mul(x12, x3);
  assign x30  = gf_mul(x15, x15);
  assign x60  = gf_mul(x30, x30);
  assign x120 = gf_mul(x60, x60);
  assign x240 = gf_mul(x120, x120);
  assign x252 = gf_mul(x240, x12);
  assign inv  = gf_mul(x252, x2);

  // Affine map: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  assign dout = inv
              ^ {inv[6:0], inv[7]}
              ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]}
              ^ 8'h63;

endmodule

// File: rtl/key_expand_iter.sv
// key_expand_iter: iterative AES key expansion, one 32-bit schedule word per cycle.
// Latency: start sampled at cycle 0 -> done at cycle 4*(nr+1)-nk+1 (41/47/53 for 128/192/256-bit keys).
// Backpressure: none; start is taken only in IDLE or DONE, ignored while busy.
// Ports: clk, rst (sync, active high), kif (slave modport: start, Key in; busy, done, keySchedule out).
// Build option: KEY_EXPAND_ZEROIZE_EN - when defined, rst and any accepted restart clear the whole
//               schedule before expansion; otherwise the schedule storage carries no reset.
module key_expand_iter #(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input  logic              clk,
  input  logic              rst,
  key_expand_iter_if.slave  kif
);
  import aes_pkg::*;

  localparam int              NW    = 4 * (nr + 1);
  localparam int              IW    = $clog2(NW + 1);
  localparam logic [IW-1:0]   LAST  = IW'(NW - 1);
  localparam logic [IW-1:0]   NK_I  = IW'(nk);
  localparam logic [2:0]      NK_M1 = 3'(nk - 1);

  kx_state_t              state;
  logic [IW-1:0]          i;
  logic [2:0]             imod;   // tracks i mod nk without a divider
  logic [7:0]             rcon;
  logic [AES_WORD_W-1:0]  w [NW];

  logic                   load;
  logic                   step;
  logic [IW-1:0]          idx_prev;
  logic [IW-1:0]          idx_back;
  logic [AES_WORD_W-1:0]  w_prev;
  logic [AES_WORD_W-1:0]  w_back;
  logic [AES_WORD_W-1:0]  sub_in;
  logic [AES_WORD_W-1:0]  sub_out;
  logic [AES_WORD_W-1:0]  temp;
  logic [AES_WORD_W-1:0]  w_new;

  assign load = kif.start && ((state == ST_IDLE) || (state == ST_DONE));
  assign step = (state == ST_EXPAND);

  assign idx_prev = i - IW'(1);
  assign idx_back = i - NK_I;
  assign w_prev   = w[idx_prev];
  assign w_back   = w[idx_back];

  // One SubWord serves both the RotWord step and the 256-bit mid-key step.
  assign sub_in = (imod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (sub_in[8*b +: 8]),
      .dout (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    temp = w_prev;
    if (imod == 3'd0) begin
      temp = sub_out ^ {rcon, 24'h000000};
    end else if ((nk == 8) && (imod == 3'd4)) begin
      temp = sub_out;
    end
  end

  assign w_new = w_back ^ temp;

  // Control path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      i     <= '0;
      imod  <= '0;
      rcon  <= RCON_INIT;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (kif.start) begin
            state <= ST_EXPAND;
            i     <= NK_I;
            imod  <= '0;
            rcon  <= RCON_INIT;
          end
        end
        ST_EXPAND: begin
          i    <= i + IW'(1);
          imod <= (imod == NK_M1) ? 3'd0 : imod + 3'd1;
          if (imod == 3'd0) rcon <= xtime(rcon);
          if (i == LAST) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Schedule storage; reset only touches it in the zeroizing build.
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef KEY_EXPAND_ZEROIZE_EN
      for (int k = 0; k < NW; k++) w[k] <= '0;
`endif
    end else if (load) begin
`ifdef KEY_EXPAND_ZEROIZE_EN
      // Clear old material first; the key words below override their slots.
      for (int k = 0; k < NW; k++) w[k] <= '0;
`endif
      for (int k = 0; k < nk; k++) w[k] <= kif.Key[AES_WORD_W*k +: AES_WORD_W];
    end else if (step) begin
      w[i] <= w_new;
    end
  end

  for (genvar k = 0; k < NW; k++) begin : g_out
    assign kif.keySchedule[AES_WORD_W*k +: AES_WORD_W] = w[k];
  end

  assign kif.busy = (state == ST_EXPAND);
  assign kif.done = (state == ST_DONE);

endmodule

// File: tb/tb_key_expand_iter.sv
// tb_key_expand_iter: scoreboard bench for key_expand_iter at 128/192/256-bit key sizes.
// Stimulus pushes the expected schedule summary; per-instance monitors pop on each rising done.
module tb_key_expand_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic rst4, rst6, rst8;

  key_expand_iter_if #(.nk(4), .nr(10)) k4 ();
  key_expand_iter_if #(.nk(6), .nr(12)) k6 ();
  key_expand_iter_if #(.nk(8), .nr(14)) k8 ();

  key_expand_iter #(.nk(4), .nr(10)) dut4 (.clk(clk), .rst(rst4), .kif(k4));
  key_expand_iter #(.nk(6), .nr(12)) dut6 (.clk(clk), .rst(rst6), .kif(k6));
  key_expand_iter #(.nk(8), .nr(14)) dut8 (.clk(clk), .rst(rst8), .kif(k8));

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] R1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [191:0] K6 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] R6 = 128'ha4970a331a78dc09c418c271e3a41d5d;
  localparam logic [255:0] K8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] R8 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

  typedef struct {
    logic [127:0] rk0;
    logic [127:0] rkl;
    logic [31:0]  w4;
    bit           w4_chk;
    int           lat;
    int           t0;
  } exp_t;

  exp_t q4[$];
  exp_t q6[$];
  exp_t q8[$];

  function automatic void check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic exp_t mk(input logic [127:0] rk0, input logic [127:0] rkl,
                              input logic [31:0] w4, input bit w4_chk, input int lat);
    exp_t e;
    e.rk0 = rk0; e.rkl = rkl; e.w4 = w4; e.w4_chk = w4_chk; e.lat = lat; e.t0 = cyc;
    return e;
  endfunction

  function automatic void score(input string nm, input exp_t e, input logic [127:0] rk0,
                                input logic [127:0] rkl, input logic [31:0] w4, input logic busy);
    check({nm, " latency"}, 128'(cyc - e.t0), 128'(e.lat));
    check({nm, " round_key_0"}, rk0, e.rk0);
    check({nm, " round_key_last"}, rkl, e.rkl);
    if (e.w4_chk) check({nm, " w4"}, 128'(w4), 128'(e.w4));
    check({nm, " busy_at_done"}, 128'(busy), 128'(0));
  endfunction

  function automatic void unexpected(input string nm);
    total++;
    bad++;
    $display("FAIL %s: done rose with no expected result queued", nm);
  endfunction

  // Monitors.
  logic d4q = 1'b0, d6q = 1'b0, d8q = 1'b0;
  always @(negedge clk) begin
    if (k4.done && !d4q) begin
      if (q4.size() == 0) unexpected("nk4");
      else score("nk4", q4.pop_front(), k4.keySchedule[0 +: 128], k4.keySchedule[1280 +: 128],
                 k4.keySchedule[128 +: 32], k4.busy);
    end
    d4q = k4.done;
  end
  always @(negedge clk) begin
    if (k6.done && !d6q) begin
      if (q6.size() == 0) unexpected("nk6");
      else score("nk6", q6.pop_front(), k6.keySchedule[0 +: 128], k6.keySchedule[1536 +: 128],
                 k6.keySchedule[128 +: 32], k6.busy);
    end
    d6q = k6.done;
  end
  always @(negedge clk) begin
    if (k8.done && !d8q) begin
      if (q8.size() == 0) unexpected("nk8");
      else score("nk8", q8.pop_front(), k8.keySchedule[0 +: 128], k8.keySchedule[1792 +: 128],
                 k8.keySchedule[128 +: 32], k8.busy);
    end
    d8q = k8.done;
  end

  function automatic logic dn(input int which);
    case (which)
      4:       return k4.done;
      6:       return k6.done;
      default: return k8.done;
    endcase
  endfunction

  task automatic wait_done(input int which);
    int n;
    n = 0;
    while (!dn(which) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL wait_done nk%0d: timeout after %0d cycles", which, n);
    end
    @(negedge clk);
  endtask

  initial begin
    rst4 = 1'b1; rst6 = 1'b1; rst8 = 1'b1;
    k4.start = 1'b0; k6.start = 1'b0; k8.start = 1'b0;
    k4.Key = '0; k6.Key = '0; k8.Key = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("reset busy nk4", 128'(k4.busy), 128'(0));
    check("reset done nk4", 128'(k4.done), 128'(0));
    check("reset busy nk6", 128'(k6.busy), 128'(0));
    check("reset done nk6", 128'(k6.done), 128'(0));
    check("reset busy nk8", 128'(k8.busy), 128'(0));
    check("reset done nk8", 128'(k8.done), 128'(0));
`ifdef KEY_EXPAND_ZEROIZE_EN
    check("reset zeroize nk4", 128'(|k4.keySchedule), 128'(0));
`endif
    rst4 = 1'b0; rst6 = 1'b0; rst8 = 1'b0;
    @(negedge clk);

    // Test 1, with a start pulse and key change during EXPAND that must be ignored.
    k4.Key = K1; k4.start = 1'b1;
    q4.push_back(mk(K1, R1, 32'hd6aa74fd, 1'b1, 41));
    @(negedge clk);
    k4.start = 1'b0;
    check("busy after start nk4", 128'(k4.busy), 128'(1));
    repeat (5) @(negedge clk);
    k4.Key = K2; k4.start = 1'b1;
    @(negedge clk);
    k4.start = 1'b0;
    wait_done(4);

    // Restart from DONE with the test-2 key.
    k4.Key = K2; k4.start = 1'b1;
    q4.push_back(mk(K2, R2, 32'ha0fafe17, 1'b1, 41));
    @(negedge clk);
    k4.start = 1'b0;
    check("done falls after restart nk4", 128'(k4.done), 128'(0));
    wait_done(4);

    // Test 5: abort a test-1 run with rst 20 cycles in; start in the same cycle loses to rst.
    k4.Key = K1; k4.start = 1'b1;
    @(negedge clk);
    k4.start = 1'b0;
    repeat (19) @(negedge clk);
    rst4 = 1'b1; k4.Key = K2; k4.start = 1'b1;
    @(negedge clk);
    rst4 = 1'b0; k4.start = 1'b0;
    check("abort busy nk4", 128'(k4.busy), 128'(0));
    check("abort done nk4", 128'(k4.done), 128'(0));
`ifdef KEY_EXPAND_ZEROIZE_EN
    check("abort zeroize nk4", 128'(|k4.keySchedule), 128'(0));
`endif
    @(negedge clk);
    k4.Key = K2; k4.start = 1'b1;
    q4.push_back(mk(K2, R2, 32'ha0fafe17, 1'b1, 41));
    @(negedge clk);
    k4.start = 1'b0;
    wait_done(4);

    // Test 3: 256-bit key.
    k8.Key = K8; k8.start = 1'b1;
    q8.push_back(mk(K1, R8, 32'h0, 1'b0, 53));
    @(negedge clk);
    k8.start = 1'b0;
    repeat (3) @(negedge clk);
    k8.Key = '1;
    wait_done(8);

    // Test 4: 192-bit key.
    k6.Key = K6; k6.start = 1'b1;
    q6.push_back(mk(K1, R6, 32'h0, 1'b0, 47));
    @(negedge clk);
    k6.start = 1'b0;
    wait_done(6);

    repeat (3) @(negedge clk);
    check("scoreboard drained", 128'(q4.size() + q6.size() + q8.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
